// File: rtl/p16_uart_pkg.sv
// Shared UART types and helpers for the uwuifier serial path.
// Used by both the buffered transmitter and the receiver.
package p16_uart_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  localparam int DATA_BITS = 8;

  // Bit period in clock cycles, truncated.
  function automatic int baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/p16_byte_fifo.sv
// Synchronous byte FIFO, first-word-fallthrough read, pushes ignored when full.
// Zero-latency head visibility; count updates on the edge after push/pop.
module p16_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [7:0]               data_i,
  input  logic                     pop_i,
  output logic [7:0]               data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/p16_uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: FIFO-absorbed bursts, back-to-back frames.
// tx falls one cycle after accept from idle; in_ready drops only when the FIFO is full.
module p16_uart_tx_buffered #(
  parameter int CLK_FREQ   = 6000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  import p16_uart_pkg::*;

  localparam int DIV = baud_div(CLK_FREQ, BAUD);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW  = $clog2(DATA_BITS);
  localparam logic [TW-1:0] RELOAD   = TW'(DIV - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  tx_state_t         state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;

  logic              fifo_pop;
  logic [7:0]        fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              bit_end;

  p16_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (in_valid),
    .data_i  (in_data),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bit_end  = (timer_q == '0);
  assign in_ready = !fifo_full;
  assign busy     = (state_q != TX_IDLE) || !fifo_empty;
  assign tx       = tx_q;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;

    case (state_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_head;
          bit_d    = '0;
          timer_d  = RELOAD;
          state_d  = TX_START;
        end
      end
      TX_START: begin
        if (bit_end) begin
          timer_d = RELOAD;
          state_d = TX_DATA;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          timer_d = RELOAD;
          if (bit_q == LAST_BIT) begin
            state_d = TX_STOP;
          end else begin
            bit_d   = bit_q + BW'(1);
            shift_d = shift_q >> 1;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      TX_STOP: begin
        if (bit_end) begin
          // Chain straight into the next start bit so bursts leave no idle gap.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_head;
            bit_d    = '0;
            timer_d  = RELOAD;
            state_d  = TX_START;
          end else begin
            state_d  = TX_IDLE;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = TX_IDLE;
    endcase

    case (state_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TX_IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_p16_uart_tx_buffered.sv
// Directed bench: frame vectors, back-to-back, full-FIFO, push/pop, reset and loopback at two baud rates.
module tb_p16_uart_tx_buffered;

  localparam int DIV_A   = 52;    // 6 MHz / 115200, truncated
  localparam int FRAME_A = 520;
  localparam int FRAME_B = 6250;  // 6 MHz / 9600 = 625 per bit

  logic       clk;
  logic       rst_n_a, rst_n_b;
  logic [7:0] in_data_a, in_data_b;
  logic       in_valid_a, in_valid_b;
  logic       in_ready_a, in_ready_b;
  logic       tx_a, tx_b;
  logic       busy_a, busy_b;
  logic [4:0] fifo_count_a, fifo_count_b;

  int cyc = 0;
  int pass_cnt = 0;
  int total_cnt = 0;
  logic [7:0] rxq_a[$];
  logic [7:0] rxq_b[$];
  int fr_err_a = 0;
  int fr_err_b = 0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;  // bit i = line level during bit time i (start first)
  } vec_t;
  vec_t vecs[4];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  p16_uart_tx_buffered #(.CLK_FREQ(6000000), .BAUD(115200), .FIFO_DEPTH(16)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .in_data(in_data_a), .in_valid(in_valid_a),
    .in_ready(in_ready_a), .tx(tx_a), .busy(busy_a), .fifo_count(fifo_count_a)
  );

  p16_uart_tx_buffered #(.CLK_FREQ(6000000), .BAUD(9600), .FIFO_DEPTH(16)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .in_data(in_data_b), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .tx(tx_b), .busy(busy_b), .fifo_count(fifo_count_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_to(input int target);
    while (cyc < target) tick();
  endtask

  function automatic logic line_of(input int which);
    return (which != 0) ? tx_b : tx_a;
  endfunction

  function automatic logic rdy_of(input int which);
    return (which != 0) ? in_ready_b : in_ready_a;
  endfunction

  function automatic logic busy_of(input int which);
    return (which != 0) ? busy_b : busy_a;
  endfunction

  task automatic push(input int which, input logic [7:0] b, input string name);
    int n = 0;
    if (which == 0) begin in_data_a = b; in_valid_a = 1'b1; end
    else            begin in_data_b = b; in_valid_b = 1'b1; end
    while (!rdy_of(which) && n < 3000) begin tick(); n++; end
    if (n == 3000) check({name, " ready timeout"}, 32'(rdy_of(which)), 32'd1);
    tick();
    if (which == 0) in_valid_a = 1'b0;
    else            in_valid_b = 1'b0;
  endtask

  task automatic wait_idle(input int which, input int bound, input string name);
    int n = 0;
    while (busy_of(which) && n < bound) begin tick(); n++; end
    check({name, " drain"}, 32'(busy_of(which)), 32'd0);
  endtask

  // Called right after the pop edge; walks all 10 bit times cycle by cycle.
  task automatic expect_frame(input logic [9:0] line, input string tag);
    int mism[10];
    logic b_last;
    b_last = 1'b0;
    foreach (mism[i]) mism[i] = 0;
    for (int t = 0; t < FRAME_A; t++) begin
      if (tx_a !== line[t / DIV_A]) mism[t / DIV_A]++;
      if (t == FRAME_A - 1) b_last = busy_a;
      tick();
    end
    for (int i = 0; i < 10; i++)
      check($sformatf("%s bit%0d bad cycles", tag, i), 32'(mism[i]), 32'd0);
    check({tag, " busy in last cycle"}, 32'(b_last), 32'd1);
  endtask

  task automatic rx_mon(input int which, input int div);
    logic [7:0] b;
    logic bad;
    forever begin
      @(posedge clk); #2;
      if (line_of(which) == 1'b0) begin
        bad = 1'b0;
        b = '0;
        repeat (div / 2) begin @(posedge clk); #2; end
        if (line_of(which) != 1'b0) bad = 1'b1;
        for (int i = 0; i < 8; i++) begin
          repeat (div) begin @(posedge clk); #2; end
          b[i] = line_of(which);
        end
        repeat (div) begin @(posedge clk); #2; end
        if (line_of(which) != 1'b1) bad = 1'b1;
        if (which == 0) begin rxq_a.push_back(b); if (bad) fr_err_a++; end
        else            begin rxq_b.push_back(b); if (bad) fr_err_b++; end
      end
    end
  endtask

  initial rx_mon(0, 52);
  initial rx_mon(1, 625);

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    string msg;
    int s, p, idx, n, low_cyc, busy_cyc;
    logic acc;

    vecs[0] = '{data: 8'h55, line: 10'h2AA};
    vecs[1] = '{data: 8'h00, line: 10'h200};
    vecs[2] = '{data: 8'hFF, line: 10'h3FE};
    vecs[3] = '{data: 8'hA3, line: 10'h346};

    msg = "hewwo uwu";
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    in_data_a = '0; in_data_b = '0;
    in_valid_a = 1'b0; in_valid_b = 1'b0;
    #2;
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    #1;
    check("rst tx", 32'(tx_a), 32'd1);
    check("rst in_ready", 32'(in_ready_a), 32'd1);
    check("rst busy", 32'(busy_a), 32'd0);
    check("rst fifo_count", 32'(fifo_count_a), 32'd0);
    check("rst tx b", 32'(tx_b), 32'd1);
    tick(); tick();
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    tick();
    check("post-rst tx", 32'(tx_a), 32'd1);
    check("post-rst busy", 32'(busy_a), 32'd0);

    fork
      begin : seq_a
        // Table: single bytes from idle.
        for (int v = 0; v < 4; v++) begin
          rxq_a.delete();
          tick();
          in_data_a = vecs[v].data;
          in_valid_a = 1'b1;
          tick();
          in_valid_a = 1'b0;
          check($sformatf("v%0d count after accept", v), 32'(fifo_count_a), 32'd1);
          check($sformatf("v%0d tx before pop", v), 32'(tx_a), 32'd1);
          tick();
          check($sformatf("v%0d tx falls after accept", v), 32'(tx_a), 32'd0);
          check($sformatf("v%0d count after pop", v), 32'(fifo_count_a), 32'd0);
          expect_frame(vecs[v].line, $sformatf("v%0d", v));
          check($sformatf("v%0d busy clear at 520", v), 32'(busy_a), 32'd0);
          check($sformatf("v%0d rx byte", v),
                (rxq_a.size() == 1) ? 32'(rxq_a[0]) : 32'h1FF, 32'(vecs[v].data));
        end

        // Back-to-back 0x00 then 0xFF.
        tick();
        in_data_a = 8'h00; in_valid_a = 1'b1;
        tick();
        in_data_a = 8'hFF;
        tick();
        in_valid_a = 1'b0;
        check("b2b count push+pop", 32'(fifo_count_a), 32'd1);
        expect_frame(10'h200, "b2b first");
        expect_frame(10'h3FE, "b2b second");
        check("b2b busy clear at 1040", 32'(busy_a), 32'd0);

        // Burst of 20 with in_valid held high.
        rxq_a.delete();
        tick();
        s = cyc;
        p = s + 2;
        idx = 0;
        in_valid_a = 1'b1;
        repeat (20) begin
          in_data_a = 8'(32'h40 + idx);
          acc = in_ready_a;
          tick();
          if (acc) idx++;
        end
        check("burst accepted", 32'(idx), 32'd17);
        check("burst count full", 32'(fifo_count_a), 32'd16);
        check("burst ready low", 32'(in_ready_a), 32'd0);
        tick_to(p + FRAME_A - 1);
        check("burst ready low before pop", 32'(in_ready_a), 32'd0);
        tick();
        check("burst ready after pop", 32'(in_ready_a), 32'd1);
        check("burst count after pop", 32'(fifo_count_a), 32'd15);
        tick();
        idx++;
        check("burst refill count", 32'(fifo_count_a), 32'd16);
        check("burst refill ready", 32'(in_ready_a), 32'd0);
        n = 0;
        while (idx < 20 && n < 3000) begin
          in_data_a = 8'(32'h40 + idx);
          acc = in_ready_a;
          tick();
          if (acc) idx++;
          n++;
        end
        in_valid_a = 1'b0;
        check("burst all accepted", 32'(idx), 32'd20);
        wait_idle(0, 20 * FRAME_A + 200, "burst");
        tick();
        check("burst rx count", 32'(rxq_a.size()), 32'd20);
        for (int i = 0; i < 20; i++)
          check($sformatf("burst rx[%0d]", i),
                (i < rxq_a.size()) ? 32'(rxq_a[i]) : 32'h1FF, 32'h40 + i);

        // Push coinciding with the stop-bit-end pop, count 3.
        rxq_a.delete();
        tick();
        s = cyc;
        p = s + 2;
        in_valid_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
          in_data_a = 8'(32'hC0 + i);
          tick();
        end
        in_valid_a = 1'b0;
        check("pp count before", 32'(fifo_count_a), 32'd3);
        tick_to(p + FRAME_A - 1);
        check("pp count at stop end", 32'(fifo_count_a), 32'd3);
        in_data_a = 8'hC4; in_valid_a = 1'b1;
        tick();
        in_valid_a = 1'b0;
        check("pp count unchanged", 32'(fifo_count_a), 32'd3);
        check("pp ready stays", 32'(in_ready_a), 32'd1);
        check("pp next start no gap", 32'(tx_a), 32'd0);
        wait_idle(0, 6 * FRAME_A, "pp");
        tick();
        check("pp rx count", 32'(rxq_a.size()), 32'd5);
        for (int i = 0; i < 5; i++)
          check($sformatf("pp rx[%0d]", i),
                (i < rxq_a.size()) ? 32'(rxq_a[i]) : 32'h1FF, 32'hC0 + i);
        check("framing errors so far", 32'(fr_err_a), 32'd0);

        // Reset during DATA bit 4 with 5 bytes queued.
        tick();
        s = cyc;
        p = s + 2;
        in_valid_a = 1'b1;
        for (int i = 0; i < 6; i++) begin
          in_data_a = 8'(32'h11 * i);
          tick();
        end
        in_valid_a = 1'b0;
        check("rst-mid queued", 32'(fifo_count_a), 32'd5);
        tick_to(p + 280);
        check("rst-mid data bit4 low", 32'(tx_a), 32'd0);
        #1;
        rst_n_a = 1'b0;
        #1;
        check("rst-mid tx high at once", 32'(tx_a), 32'd1);
        check("rst-mid count cleared", 32'(fifo_count_a), 32'd0);
        check("rst-mid busy cleared", 32'(busy_a), 32'd0);
        tick(); tick();
        rst_n_a = 1'b1;
        tick();
        check("rst-mid count after release", 32'(fifo_count_a), 32'd0);
        check("rst-mid busy after release", 32'(busy_a), 32'd0);
        check("rst-mid ready after release", 32'(in_ready_a), 32'd1);
        low_cyc = 0;
        busy_cyc = 0;
        repeat (700) begin
          if (!tx_a) low_cyc++;
          if (busy_a) busy_cyc++;
          tick();
        end
        check("rst-mid no further frames", 32'(low_cyc), 32'd0);
        check("rst-mid stays idle", 32'(busy_cyc), 32'd0);
        rxq_a.delete();
        fr_err_a = 0;

        // Loopback at 115200.
        for (int i = 0; i < msg.len(); i++) push(0, 8'(msg[i]), "loop a");
        wait_idle(0, 12 * FRAME_A, "loop a");
        tick();
        check("loop a rx count", 32'(rxq_a.size()), 32'(msg.len()));
        for (int i = 0; i < msg.len(); i++)
          check($sformatf("loop a char %0d", i),
                (i < rxq_a.size()) ? 32'(rxq_a[i]) : 32'h1FF, 32'(msg[i]));
        check("loop a framing errors", 32'(fr_err_a), 32'd0);
      end
      begin : seq_b
        for (int i = 0; i < msg.len(); i++) push(1, 8'(msg[i]), "loop b");
        wait_idle(1, 10 * FRAME_B, "loop b");
        tick();
        check("loop b rx count", 32'(rxq_b.size()), 32'(msg.len()));
        for (int i = 0; i < msg.len(); i++)
          check($sformatf("loop b char %0d", i),
                (i < rxq_b.size()) ? 32'(rxq_b[i]) : 32'h1FF, 32'(msg[i]));
        check("loop b framing errors", 32'(fr_err_b), 32'd0);
      end
    join

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
